vram_arbiter: RTL and testbench
===============================

# vram_arbiter

Time-slot arbiter for the single 512 KB asynchronous SRAM, shared between the screen controller's video fetch and the Z80 memory requests. It sits between the screen block and the SRAM pins. Each 14 MHz slot, it decides whether video or the CPU owns the RAM, drives `fetch_allow` back to the screen, and generates SRAM address and strobes. A starvation guard keeps the CPU from being locked out for a whole paper line.

## Interface
- `STARVE_LIMIT`, default 3: number of consecutive slots the CPU may lose to video before it is forced a slot.
- `clk28`  in  1  system clock, 28 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ck14`  in  1  slot strobe from the screen block, high on every second `clk28` cycle.
- `video_want`  in  1  screen wants the next slot (its `loading || up_en` term).
- `video_fetch`  in  1  screen's `fetch` register: the current slot is a video slot.
- `video_up`  in  1  the current video slot is a palette fetch and does not use the SRAM.
- `video_page`  in  1  port 7FFD bit 3: shadow screen select.
- `video_addr`  in  15  screen address.
- `fetch_allow`  out  1  the screen may take the next slot.
- `cpu_req`  in  1  CPU memory request, level.
- `cpu_wr`  in  1  1 = write, 0 = read; valid with `cpu_req`.
- `cpu_addr`  in  19  physical address.
- `cpu_wdata`  in  8  write data.
- `cpu_rdata`  out  8  read data, held until the next read completes.
- `cpu_done`  out  1  one-cycle completion pulse.
- `cpu_wait`  out  1  the request is pending and not yet done.
- `ram_a`  out  19  SRAM address.
- `ram_oe_n`  out  1  SRAM output enable, active-low.
- `ram_we_n`  out  1  SRAM write enable, active-low.
- `ram_dout`  out  8  SRAM write data.
- `ram_dout_en`  out  1  data bus drive enable.
- `ram_din`  in  8  SRAM read data.

## Operation
- **Slots**
  - One slot is 2 `clk28` cycles.
  - A slot begins on the cycle after a `ck14`-high cycle.
  - The owner of slot N+1 is decided on the `ck14` cycle that ends slot N.
- **Owner FSM**
  - States: IDLE, VID, CPU_RD, CPU_WR.
  - Next state is computed at `ck14`:
    - CPU_WR if `cpu_pend & cpu_wr & cpu_sel`.
    - CPU_RD if `cpu_pend & !cpu_wr & cpu_sel`.
    - otherwise VID if `video_want`.
    - otherwise IDLE.
  - `cpu_sel = !video_want | (starve_cnt == STARVE_LIMIT)`.
  - Exception: if the next video slot is a palette fetch (`video_up` flagged by the screen), the CPU also takes the SRAM in that slot. `video_fetch` stays asserted.
- **fetch_allow**: combinational, `= !(cpu_pend & (starve_cnt == STARVE_LIMIT))`. It is valid during the `ck14` cycle, when the screen samples it.
- **starve_cnt**
  - Increments (saturating at `STARVE_LIMIT`) at each `ck14` where `cpu_pend` is set and VID is chosen.
  - Clears when a CPU slot is granted or `cpu_pend` is 0.
- **Address mapping**
  - VID: `ram_a = {5'b00,1,video_page,1 → bank 5/7, video_addr[13:0]}`, i.e. `{3'b001, video_page, 1'b1, video_addr[13:0]}`.
  - CPU: `ram_a = cpu_addr`.
- **Strobes**
  - VID, CPU_RD: `ram_oe_n` is low for both slot cycles.
  - CPU_WR: `ram_dout_en` is 1 for both cycles; `ram_we_n` is low only in the second cycle.
  - IDLE: all strobes inactive; `ram_a` holds its last value.
- **CPU completion**
  - `cpu_pend = cpu_req & !served`.
  - At the end of a CPU slot, `served` sets, `cpu_rdata` latches `ram_din` (reads only), and `cpu_done` pulses in the next cycle.
  - `served` clears when `cpu_req` falls.
  - `cpu_wait = cpu_req & !served`.

## Timing
- **Reset**: `fetch_allow`=1, `cpu_done`=0, `cpu_wait`=0, `cpu_rdata`=0, `ram_oe_n`=1, `ram_we_n`=1, `ram_dout_en`=0, `ram_a`=0, FSM=IDLE, `starve_cnt`=0.
- **Reset mid-slot**: strobes go inactive asynchronously; any access in flight is dropped.
- **CPU latency**
  - Best case: `cpu_req` raised → `cpu_done` 3–4 clk28 later.
  - Worst case: (`STARVE_LIMIT`+1) slots + 2 cycles.
- **Video latency**: the `video_fetch` slot data is valid on `ram_din` at the closing `ck14`, matching the screen's sampling point.
- **Request protocol**: `cpu_req` and the address/data stay stable until `cpu_done`. A new request may be raised one cycle after `cpu_req` falls.

## Configuration
- **`CPU_POSTED_WRITE_EN`**: a one-entry write buffer.
  - **With the macro**
    - A write is accepted when the buffer is empty; `cpu_done` pulses the next cycle.
    - The buffer drains in the next CPU slot.
    - A write arriving while the buffer is full waits.
    - A read while the buffer is full waits until it has drained, preserving read-after-write order.
  - **Without the macro**: writes complete in their slot, like reads.

## Test plan
- **CPU read, video idle**: `video_want`=0, read 19'h12345 → CPU_RD slot, `ram_a`=12345, `cpu_rdata`=`ram_din`, `cpu_done` 1 cycle after the slot.
- **Starvation**: `video_want` held 1, `STARVE_LIMIT`=3, CPU read pending → exactly 3 VID slots, then `fetch_allow`=0 at `ck14` and a CPU slot follows; `starve_cnt` returns to 0.
- **Video mapping**: `video_page`=1, `video_addr`=15'h5800 → `ram_a`=19'h1D800, `ram_oe_n`=0.
- **Write strobe**: write 8'hA5 to 19'h7FFFF → `ram_we_n` low only in the slot's second cycle, `ram_dout_en` high for both cycles.
- **Palette slot**: `video_up`=1 with a CPU read pending → the CPU is served in that slot and `fetch_allow` stays 1.
- **Reset and posted write**: reset asserted mid CPU_WR → `ram_we_n`=1 immediately. With `CPU_POSTED_WRITE_EN`, a write followed by a read → read `ram_a` is issued only after the buffered write slot.

Source files
------------

// File: rtl/vram_arbiter_if.sv
// Screen / CPU / SRAM bundle around the VRAM slot arbiter.
// The arbiter takes the slave side; screen, CPU and SRAM sit on master.
interface vram_arbiter_if;
  logic        ck14;
  logic        video_want;
  logic        video_fetch;
  logic        video_up;
  logic        video_page;
  logic [14:0] video_addr;
  logic        fetch_allow;
  logic        cpu_req;
  logic        cpu_wr;
  logic [18:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_done;
  logic        cpu_wait;
  logic [18:0] ram_a;
  logic        ram_oe_n;
  logic        ram_we_n;
  logic [7:0]  ram_dout;
  logic        ram_dout_en;
  logic [7:0]  ram_din;

  modport slave (
    input  ck14, video_want, video_fetch, video_up,
    input  video_page, video_addr,
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata, ram_din,
    output fetch_allow, cpu_rdata, cpu_done, cpu_wait,
    output ram_a, ram_oe_n, ram_we_n, ram_dout, ram_dout_en
  );

  modport master (
    output ck14, video_want, video_fetch, video_up,
    output video_page, video_addr,
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata, ram_din,
    input  fetch_allow, cpu_rdata, cpu_done, cpu_wait,
    input  ram_a, ram_oe_n, ram_we_n, ram_dout, ram_dout_en
  );
endinterface

// File: rtl/vram_arbiter.sv
// Slot arbiter sharing the SRAM between video fetch and Z80 requests.
// Define CPU_POSTED_WRITE_EN for a one-entry posted write buffer.
module vram_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input logic           clk28,
  input logic           rst_n,
  vram_arbiter_if.slave b
);

  localparam int CW =
    (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE, VID, CPU_RD, CPU_WR
  } st_t;

  st_t         st;
  logic [CW-1:0] starve_cnt;
  logic        served;
  logic        done;
  logic [7:0]  rdata;
  logic [18:0] ram_a;
  logic        oe_n;
  logic        we_n;
  logic [7:0]  dout;
  logic        dout_en;

  logic        in_cpu;
  logic        pend;
  logic        pend_wr;
  logic        at_lim;
  logic        cpu_sel;
  logic        go_wr;
  logic        go_rd;
  logic        go_vid;
  logic [18:0] wr_a;
  logic [7:0]  wr_d;
  logic [18:0] vid_a;

  assign in_cpu = (st == CPU_RD) || (st == CPU_WR);

  // A request in its own slot is in flight, not pending.
`ifdef CPU_POSTED_WRITE_EN
  logic        wb_vld;
  logic [18:0] wb_a;
  logic [7:0]  wb_d;
  logic        take_wr;

  assign take_wr = b.cpu_req & b.cpu_wr
                 & !served & !wb_vld;
  assign pend_wr = wb_vld;
  assign pend    = !in_cpu & (wb_vld
                 | (b.cpu_req & !b.cpu_wr & !served));
  assign wr_a    = wb_a;
  assign wr_d    = wb_d;
`else
  assign pend_wr = b.cpu_wr;
  assign pend    = !in_cpu & b.cpu_req & !served;
  assign wr_a    = b.cpu_addr;
  assign wr_d    = b.cpu_wdata;
`endif

  assign at_lim  = starve_cnt == CW'(STARVE_LIMIT);
  assign cpu_sel = !b.video_want | at_lim | b.video_up;
  assign go_wr   = pend & pend_wr & cpu_sel;
  assign go_rd   = pend & !pend_wr & cpu_sel;
  assign go_vid  = !(go_wr | go_rd) & b.video_want;
  assign vid_a   = {3'b001, b.video_page, 1'b1,
                    b.video_addr[13:0]};

  assign b.fetch_allow = !(pend & at_lim);
  assign b.cpu_wait    = b.cpu_req & !served;
  assign b.cpu_done    = done;
  assign b.cpu_rdata   = rdata;
  assign b.ram_a       = ram_a;
  assign b.ram_oe_n    = oe_n;
  assign b.ram_we_n    = we_n;
  assign b.ram_dout    = dout;
  assign b.ram_dout_en = dout_en;

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      st         <= IDLE;
      starve_cnt <= '0;
      served     <= 1'b0;
      done       <= 1'b0;
      rdata      <= '0;
      ram_a      <= '0;
      oe_n       <= 1'b1;
      we_n       <= 1'b1;
      dout       <= '0;
      dout_en    <= 1'b0;
`ifdef CPU_POSTED_WRITE_EN
      wb_vld     <= 1'b0;
      wb_a       <= '0;
      wb_d       <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (!b.cpu_req) served <= 1'b0;

      if (!pend) starve_cnt <= '0;
      else if (b.ck14) begin
        if (go_vid && !at_lim)
          starve_cnt <= starve_cnt + 1'b1;
        else if (go_rd || go_wr)
          starve_cnt <= '0;
      end

`ifdef CPU_POSTED_WRITE_EN
      if (take_wr) begin
        wb_vld <= 1'b1;
        wb_a   <= b.cpu_addr;
        wb_d   <= b.cpu_wdata;
        served <= 1'b1;
        done   <= 1'b1;
      end
`endif

      if (b.ck14) begin
        if (st == CPU_RD) begin
          served <= 1'b1;
          done   <= 1'b1;
          rdata  <= b.ram_din;
        end
        if (st == CPU_WR) begin
`ifdef CPU_POSTED_WRITE_EN
          wb_vld <= 1'b0;
`else
          served <= 1'b1;
          done   <= 1'b1;
`endif
        end
        we_n <= 1'b1;
        unique case (1'b1)
          go_wr: begin
            st      <= CPU_WR;
            ram_a   <= wr_a;
            dout    <= wr_d;
            dout_en <= 1'b1;
            oe_n    <= 1'b1;
          end
          go_rd: begin
            st      <= CPU_RD;
            ram_a   <= b.cpu_addr;
            dout_en <= 1'b0;
            oe_n    <= 1'b0;
          end
          go_vid: begin
            st      <= VID;
            ram_a   <= vid_a;
            dout_en <= 1'b0;
            oe_n    <= 1'b0;
          end
          default: begin
            st      <= IDLE;
            dout_en <= 1'b0;
            oe_n    <= 1'b1;
          end
        endcase
      end else if (st == CPU_WR) begin
        // Write pulse sits in the second half of the slot.
        we_n <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter.
// SRAM model: ram_din = ram_a[7:0] ^ 8'h5A.
module tb_vram_arbiter;

  logic clk28 = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  vram_arbiter_if bi();

  vram_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk28 (clk28),
    .rst_n (rst_n),
    .b     (bi)
  );

  always #5 clk28 = ~clk28;

  always @(posedge clk28 or negedge rst_n)
    if (!rst_n) bi.ck14 <= 1'b0;
    else        bi.ck14 <= ~bi.ck14;

  assign bi.ram_din = bi.ram_a[7:0] ^ 8'h5A;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk28);
    #1;
  endtask

  task automatic to_ck14;
    int n = 0;
    while (bi.ck14 !== 1'b1 && n < 4) begin
      step();
      n++;
    end
    if (bi.ck14 !== 1'b1) begin
      total++;
      bad++;
      $error("FAIL ck14_timeout got=0 exp=1");
    end
  endtask

  task automatic wait_dout_en;
    int n = 0;
    do begin
      step();
      n++;
    end while (bi.ram_dout_en !== 1'b1 && n < 8);
    chk("wr_slot_seen", bi.ram_dout_en, 1);
  endtask

  task automatic wait_sig(input string tag,
                          input int which);
    int n = 0;
    do begin
      step();
      n++;
    end while (n < 12 &&
      ((which == 0 && bi.ram_oe_n !== 1'b0) ||
       (which == 1 && bi.cpu_done !== 1'b1)));
    if (which == 0) chk(tag, bi.ram_oe_n, 0);
    else            chk(tag, bi.cpu_done, 1);
  endtask

  initial begin
    bi.video_want  = 1'b0;
    bi.video_fetch = 1'b0;
    bi.video_up    = 1'b0;
    bi.video_page  = 1'b0;
    bi.video_addr  = '0;
    bi.cpu_req     = 1'b0;
    bi.cpu_wr      = 1'b0;
    bi.cpu_addr    = '0;
    bi.cpu_wdata   = '0;

    repeat (2) @(posedge clk28);
    #1;
    chk("rst_fetch_allow", bi.fetch_allow, 1);
    chk("rst_done", bi.cpu_done, 0);
    chk("rst_wait", bi.cpu_wait, 0);
    chk("rst_rdata", bi.cpu_rdata, 0);
    chk("rst_oe_n", bi.ram_oe_n, 1);
    chk("rst_we_n", bi.ram_we_n, 1);
    chk("rst_dout_en", bi.ram_dout_en, 0);
    chk("rst_ram_a", bi.ram_a, 0);
    rst_n = 1'b1;

    // CPU read, video idle
    to_ck14();
    bi.cpu_req  = 1'b1;
    bi.cpu_wr   = 1'b0;
    bi.cpu_addr = 19'h12345;
    #1;
    chk("rd_wait", bi.cpu_wait, 1);
    chk("rd_fa", bi.fetch_allow, 1);
    step();
    chk("rd_a", bi.ram_a, 19'h12345);
    chk("rd_oe0", bi.ram_oe_n, 0);
    chk("rd_we0", bi.ram_we_n, 1);
    chk("rd_nodone0", bi.cpu_done, 0);
    step();
    chk("rd_oe1", bi.ram_oe_n, 0);
    chk("rd_nodone1", bi.cpu_done, 0);
    step();
    chk("rd_done", bi.cpu_done, 1);
    chk("rd_rdata", bi.cpu_rdata, 8'h1F);
    chk("rd_wait_lo", bi.cpu_wait, 0);
    chk("rd_oe_off", bi.ram_oe_n, 1);
    bi.cpu_req = 1'b0;
    step();
    chk("rd_done_pulse", bi.cpu_done, 0);

    // Write strobe
    to_ck14();
    bi.cpu_req   = 1'b1;
    bi.cpu_wr    = 1'b1;
    bi.cpu_addr  = 19'h7FFFF;
    bi.cpu_wdata = 8'hA5;
    wait_dout_en();
    chk("wr_a", bi.ram_a, 19'h7FFFF);
    chk("wr_dout", bi.ram_dout, 8'hA5);
    chk("wr_we_c0", bi.ram_we_n, 1);
    chk("wr_oe_c0", bi.ram_oe_n, 1);
    step();
    chk("wr_we_c1", bi.ram_we_n, 0);
    chk("wr_en_c1", bi.ram_dout_en, 1);
    step();
`ifndef CPU_POSTED_WRITE_EN
    chk("wr_done", bi.cpu_done, 1);
`endif
    chk("wr_we_off", bi.ram_we_n, 1);
    chk("wr_en_off", bi.ram_dout_en, 0);
    bi.cpu_req = 1'b0;
    bi.cpu_wr  = 1'b0;
    step();

    // Video mapping
    bi.video_want  = 1'b1;
    bi.video_fetch = 1'b1;
    bi.video_page  = 1'b1;
    bi.video_addr  = 15'h5800;
    to_ck14();
    step();
    chk("vid_a", bi.ram_a, 19'h1D800);
    chk("vid_oe", bi.ram_oe_n, 0);
    step();

    // Palette slot lets the CPU in
    to_ck14();
    bi.video_up = 1'b1;
    bi.cpu_req  = 1'b1;
    bi.cpu_addr = 19'h00321;
    #1;
    chk("pal_fa0", bi.fetch_allow, 1);
    step();
    chk("pal_a", bi.ram_a, 19'h00321);
    chk("pal_oe", bi.ram_oe_n, 0);
    step();
    chk("pal_fa1", bi.fetch_allow, 1);
    step();
    chk("pal_done", bi.cpu_done, 1);
    chk("pal_rdata", bi.cpu_rdata, 8'h7B);
    bi.cpu_req  = 1'b0;
    bi.video_up = 1'b0;
    step();

    // Starvation guard
    to_ck14();
    bi.cpu_req  = 1'b1;
    bi.cpu_addr = 19'h00ABC;
    #1;
    chk("st_fa_k0", bi.fetch_allow, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("st_vid_a", bi.ram_a, 19'h1D800);
      step();
      chk("st_cnt", dut.starve_cnt, i + 1);
      chk("st_fa", bi.fetch_allow, (i == 2) ? 0 : 1);
    end
    step();
    chk("st_cpu_a", bi.ram_a, 19'h00ABC);
    chk("st_cnt_clr", dut.starve_cnt, 0);
    step();
    chk("st_fa_back", bi.fetch_allow, 1);
    step();
    chk("st_done", bi.cpu_done, 1);
    chk("st_rdata", bi.cpu_rdata, 8'hE6);
    bi.cpu_req    = 1'b0;
    bi.video_want = 1'b0;
    step();

    // Reset in the middle of a write slot
    to_ck14();
    bi.cpu_req   = 1'b1;
    bi.cpu_wr    = 1'b1;
    bi.cpu_addr  = 19'h00100;
    bi.cpu_wdata = 8'h77;
    wait_dout_en();
    step();
    chk("mr_we_pre", bi.ram_we_n, 0);
    rst_n = 1'b0;
    #1;
    chk("mr_we", bi.ram_we_n, 1);
    chk("mr_en", bi.ram_dout_en, 0);
    chk("mr_oe", bi.ram_oe_n, 1);
    chk("mr_a", bi.ram_a, 0);
    bi.cpu_req = 1'b0;
    bi.cpu_wr  = 1'b0;
    step();
    rst_n = 1'b1;
    step();

`ifdef CPU_POSTED_WRITE_EN
    // Posted write then read keeps order
    to_ck14();
    bi.cpu_req   = 1'b1;
    bi.cpu_wr    = 1'b1;
    bi.cpu_addr  = 19'h00055;
    bi.cpu_wdata = 8'h3C;
    step();
    chk("pw_done", bi.cpu_done, 1);
    chk("pw_idle_en", bi.ram_dout_en, 0);
    bi.cpu_req = 1'b0;
    bi.cpu_wr  = 1'b0;
    step();
    bi.cpu_req  = 1'b1;
    bi.cpu_addr = 19'h00077;
    step();
    chk("pw_drain_a", bi.ram_a, 19'h00055);
    chk("pw_drain_en", bi.ram_dout_en, 1);
    chk("pw_drain_d", bi.ram_dout, 8'h3C);
    wait_sig("pw_rd_oe", 0);
    chk("pw_rd_a", bi.ram_a, 19'h00077);
    wait_sig("pw_rd_done", 1);
    chk("pw_rd_rdata", bi.cpu_rdata, 8'h2D);
    bi.cpu_req = 1'b0;
    step();
`endif

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
